// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM between a fixed-priority cpu port and a dma port with starvation guard
module ram_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 4,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wdata_en,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [2:0]        wait_cnt
);
  typedef enum logic [1:0] {IDLE, ACC_CPU, ACC_DMA} state_t;
  state_t state;
  logic dma_win, cpu_win;
  always_comb begin
    dma_win = dma_req && (wait_cnt == 3'(MAX_WAIT) || !cpu_req);
    cpu_win = cpu_req && !dma_win;
  end
  assign ram_wdata_en = ram_cs & ram_we;
  // ram_addr/ram_we/ram_wdata double as the command register; they read 0 outside an access
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cpu_gnt    <= 1'b0;
      dma_gnt    <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      ram_addr   <= '0;
      ram_cs     <= 1'b0;
      ram_we     <= 1'b0;
      ram_wdata  <= '0;
      wait_cnt   <= '0;
    end else begin
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      if (state == IDLE) begin
        wait_cnt <= (!dma_req || dma_win) ? 3'd0 :
                    (wait_cnt == 3'(MAX_WAIT)) ? wait_cnt : wait_cnt + 3'd1;
        if (cpu_win || dma_win) begin
          state     <= cpu_win ? ACC_CPU : ACC_DMA;
          cpu_gnt   <= cpu_win;
          dma_gnt   <= dma_win;
          ram_cs    <= 1'b1;
          ram_addr  <= cpu_win ? cpu_addr : dma_addr;
          ram_we    <= cpu_win ? cpu_we : dma_we;
          ram_wdata <= cpu_win ? cpu_wdata : dma_wdata;
        end
      end else begin
        state     <= IDLE;
        cpu_gnt   <= 1'b0;
        dma_gnt   <= 1'b0;
        ram_cs    <= 1'b0;
        ram_we    <= 1'b0;
        ram_addr  <= '0;
        ram_wdata <= '0;
        if (!ram_we && state == ACC_CPU) begin
          cpu_rdata  <= ram_rdata;
          cpu_rvalid <= 1'b1;
        end
        if (!ram_we && state == ACC_DMA) begin
          dma_rdata  <= ram_rdata;
          dma_rvalid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of arbitration, read return, starvation guard and reset abort
module tb_ram_arbiter;
  logic clock = 0, reset = 1;
  logic cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [11:0] cpu_addr = 0, dma_addr = 0, ram_addr;
  logic [3:0] cpu_wdata = 0, dma_wdata = 0, cpu_rdata, dma_rdata, ram_wdata, ram_rdata;
  logic cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, ram_cs, ram_we, ram_wdata_en;
  logic [2:0] wait_cnt;
  logic [3:0] mem [0:4095];
  int checks = 0, errors = 0;

  ram_arbiter #(.ADDR_W(12), .DATA_W(4), .MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_wdata_en(ram_wdata_en), .ram_rdata(ram_rdata), .wait_cnt(wait_cnt)
  );

  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (reset) mem[12'hFFF] <= 4'h3;
    else if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = mem[ram_addr];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) step();
    checks++;
    if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, ram_cs, ram_we, ram_wdata_en, cpu_rdata, dma_rdata, ram_addr, ram_wdata, wait_cnt} !== 38'd0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b%b rv=%b%b cs=%b we=%b en=%b addr=%h wc=%0d expected all 0", cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, ram_cs, ram_we, ram_wdata_en, ram_addr, wait_cnt);
    end
    reset = 0;
    step();
  endtask

  task automatic test_cpu_write_read();
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h0A5; cpu_wdata = 4'h9;
    step();
    checks++;
    if ({cpu_gnt, dma_gnt, ram_cs, ram_we, ram_wdata_en} !== 5'b10111 || ram_addr !== 12'h0A5 || ram_wdata !== 4'h9) begin
      errors++;
      $display("FAIL cpu_write_cycle got gnt=%b%b cs=%b we=%b en=%b addr=%h wdata=%h expected 10 1 1 1 0a5 9", cpu_gnt, dma_gnt, ram_cs, ram_we, ram_wdata_en, ram_addr, ram_wdata);
    end
    cpu_req = 0; cpu_we = 0; cpu_wdata = 0;
    step();
    checks++;
    if ({cpu_gnt, ram_cs, cpu_rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL cpu_write_end got gnt=%b cs=%b rvalid=%b expected 000", cpu_gnt, ram_cs, cpu_rvalid);
    end
    cpu_req = 1;
    step();
    checks++;
    if ({cpu_gnt, dma_gnt, ram_cs, ram_we, ram_wdata_en} !== 5'b10100 || ram_addr !== 12'h0A5) begin
      errors++;
      $display("FAIL cpu_read_cycle got gnt=%b%b cs=%b we=%b en=%b addr=%h expected 10 1 0 0 0a5", cpu_gnt, dma_gnt, ram_cs, ram_we, ram_wdata_en, ram_addr);
    end
    cpu_req = 0;
    step();
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 4'h9 || dma_gnt !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_return got rvalid=%b rdata=%h dma_gnt=%b expected 1 9 0", cpu_rvalid, cpu_rdata, dma_gnt);
    end
    step();
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 4'h9) begin
      errors++;
      $display("FAIL cpu_rvalid_pulse got rvalid=%b rdata=%h expected 0 9", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_contention();
    cpu_req = 1; cpu_addr = 12'h0A5; dma_req = 1; dma_we = 0; dma_addr = 12'h0A5;
    step();
    checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b10 || wait_cnt !== 3'd1) begin
      errors++;
      $display("FAIL contention_cpu_first got gnt=%b%b wait_cnt=%0d expected 10 1", cpu_gnt, dma_gnt, wait_cnt);
    end
    cpu_req = 0;
    step();
    checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b00 || wait_cnt !== 3'd1) begin
      errors++;
      $display("FAIL contention_gap got gnt=%b%b wait_cnt=%0d expected 00 1", cpu_gnt, dma_gnt, wait_cnt);
    end
    step();
    checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b01 || wait_cnt !== 3'd0) begin
      errors++;
      $display("FAIL contention_dma_next got gnt=%b%b wait_cnt=%0d expected 01 0", cpu_gnt, dma_gnt, wait_cnt);
    end
    dma_req = 0;
    step();
    checks++;
    if ({dma_rvalid, cpu_rvalid} !== 2'b10 || dma_rdata !== 4'h9) begin
      errors++;
      $display("FAIL contention_dma_read got rvalid dma/cpu=%b%b rdata=%h expected 10 9", dma_rvalid, cpu_rvalid, dma_rdata);
    end
  endtask

  task automatic test_starvation();
    logic [1:0] exp_gnt [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
    logic [2:0] exp_wc  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h0A5; dma_req = 1; dma_we = 0; dma_addr = 12'h0A5;
    for (int r = 0; r < 6; r++) begin
      step();
      checks++;
      if ({cpu_gnt, dma_gnt} !== exp_gnt[r] || wait_cnt !== exp_wc[r]) begin
        errors++;
        $display("FAIL starvation_round%0d got gnt=%b%b wait_cnt=%0d expected %b %0d", r + 1, cpu_gnt, dma_gnt, wait_cnt, exp_gnt[r], exp_wc[r]);
      end
      if (r == 5) begin
        cpu_req = 0; dma_req = 0;
      end
      step();
    end
    step();
    checks++;
    if (wait_cnt !== 3'd0) begin
      errors++;
      $display("FAIL starvation_clear got wait_cnt=%0d expected 0", wait_cnt);
    end
  endtask

  task automatic test_dma_read_fff();
    dma_req = 1; dma_we = 0; dma_addr = 12'hFFF;
    step();
    checks++;
    if ({cpu_gnt, dma_gnt, ram_cs, ram_we} !== 4'b0110 || ram_addr !== 12'hFFF) begin
      errors++;
      $display("FAIL dma_fff_cycle got gnt=%b%b cs=%b we=%b addr=%h expected 01 1 0 fff", cpu_gnt, dma_gnt, ram_cs, ram_we, ram_addr);
    end
    dma_req = 0;
    step();
    checks++;
    if ({dma_rvalid, cpu_rvalid} !== 2'b10 || dma_rdata !== 4'h3 || cpu_rdata !== 4'h9) begin
      errors++;
      $display("FAIL dma_fff_return got rvalid dma/cpu=%b%b dma_rdata=%h cpu_rdata=%h expected 10 3 9", dma_rvalid, cpu_rvalid, dma_rdata, cpu_rdata);
    end
  endtask

  task automatic test_reset_during_acc();
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h0A5; dma_req = 1; dma_addr = 12'h001;
    step();
    checks++;
    if ({cpu_gnt, ram_cs} !== 2'b11 || wait_cnt !== 3'd1) begin
      errors++;
      $display("FAIL abort_setup got gnt=%b cs=%b wait_cnt=%0d expected 1 1 1", cpu_gnt, ram_cs, wait_cnt);
    end
    reset = 1; cpu_req = 0; dma_req = 0;
    step();
    checks++;
    if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, ram_cs, ram_we, ram_wdata_en, cpu_rdata, dma_rdata, ram_addr, ram_wdata, wait_cnt} !== 38'd0) begin
      errors++;
      $display("FAIL abort_outputs got gnt=%b%b rv=%b%b cs=%b addr=%h rdata=%h wc=%0d expected all 0", cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, ram_cs, ram_addr, cpu_rdata, wait_cnt);
    end
    reset = 0;
    step();
    checks++;
    if ({cpu_rvalid, cpu_gnt, ram_cs} !== 3'b000) begin
      errors++;
      $display("FAIL abort_no_rvalid got rvalid=%b gnt=%b cs=%b expected 000", cpu_rvalid, cpu_gnt, ram_cs);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({ram_cs, ram_we, ram_wdata_en, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid} !== 7'd0) begin
        errors++;
        $display("FAIL idle_cycle%0d got cs/we/en/gnt/rv=%b expected 0000000", i, {ram_cs, ram_we, ram_wdata_en, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid});
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write_read();
    test_contention();
    test_starvation();
    test_dma_read_fff();
    test_reset_during_acc();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
